// File: rtl/exu_scheduler.sv
// exu_scheduler: single-issue ALU/FPU operation scheduler.
// Accepts one operation at a time, drives registered opcode/select controls to the
// datapath, captures the datapath result after a fixed latency and holds it until the
// consumer handshakes it away. flush aborts any in-flight or pending operation.
// Optional feature: define EXU_EXC_STICKY_EN to build the sticky FPU exception flag;
// without it exc_sticky is tied low and exc_clear is ignored.
module exu_scheduler #(
    parameter int unsigned FPU_LATENCY = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fpu,
    input  logic [2:0]  req_alu_op,
    input  logic [2:0]  req_fpu_op,
    input  logic [4:0]  req_tag,
    output logic [2:0]  alu_opcode,
    output logic [2:0]  fpu_opcode,
    output logic        alu_fpu_select,
    input  logic [31:0] dp_result,
    input  logic        dp_exception,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_tag,
    output logic        resp_exception,
    input  logic        exc_clear,
    output logic        exc_sticky
);

    typedef enum logic [1:0] {
        StIdle,
        StAluExec,
        StFpuWait,
        StResp
    } state_e;

    // Counter starts at FPU_LATENCY-1 so the capture lands on edge accept+FPU_LATENCY.
    localparam logic [3:0] CntLoad = 4'(FPU_LATENCY - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  tag_q;
    logic        accept;
    logic        fpu_capture;

    assign req_ready   = (state_q == StIdle) && !flush;
    assign resp_valid  = (state_q == StResp);
    assign accept      = req_valid && req_ready;
    assign fpu_capture = (state_q == StFpuWait) && (cnt_q == 4'd0) && !flush;

    // Control FSM: accept, wait for the datapath, capture, hold until handshake.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            tag_q          <= 5'd0;
            alu_opcode     <= 3'd0;
            fpu_opcode     <= 3'd0;
            alu_fpu_select <= 1'b0;
            resp_result    <= 32'd0;
            resp_tag       <= 5'd0;
            resp_exception <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        alu_opcode     <= req_alu_op;
                        fpu_opcode     <= req_fpu_op;
                        alu_fpu_select <= req_fpu;
                        tag_q          <= req_tag;
                        if (req_fpu) begin
                            cnt_q   <= CntLoad;
                            state_q <= StFpuWait;
                        end else begin
                            state_q <= StAluExec;
                        end
                    end
                end
                StAluExec: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        resp_result    <= dp_result;
                        resp_tag       <= tag_q;
                        resp_exception <= 1'b0;
                        state_q        <= StResp;
                    end
                end
                StFpuWait: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 4'd0) begin
                        resp_result    <= dp_result;
                        resp_tag       <= tag_q;
                        resp_exception <= dp_exception;
                        state_q        <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // flush discards the pending response even when resp_ready is high.
                    if (flush || resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef EXU_EXC_STICKY_EN
    logic sticky_q;

    // Sticky exception: set by an FPU capture with exception; set beats clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (fpu_capture && dp_exception) begin
            sticky_q <= 1'b1;
        end else if (exc_clear) begin
            sticky_q <= 1'b0;
        end
    end

    assign exc_sticky = sticky_q;
`else
    logic unused_sticky_inputs;
    assign unused_sticky_inputs = exc_clear ^ fpu_capture;
    assign exc_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_exu_scheduler.sv
// tb_exu_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model (accept time + latency = capture time).
// Honours EXU_EXC_STICKY_EN the same way as the design.
module tb_exu_scheduler;

    localparam int unsigned Lat = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_fpu = 1'b0;
    logic [2:0]  req_alu_op = 3'd0;
    logic [2:0]  req_fpu_op = 3'd0;
    logic [4:0]  req_tag = 5'd0;
    logic [2:0]  alu_opcode;
    logic [2:0]  fpu_opcode;
    logic        alu_fpu_select;
    logic [31:0] dp_result = 32'd0;
    logic        dp_exception = 1'b0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;
    logic        resp_exception;
    logic        exc_clear = 1'b0;
    logic        exc_sticky;

    exu_scheduler #(.FPU_LATENCY(Lat)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_fpu        (req_fpu),
        .req_alu_op     (req_alu_op),
        .req_fpu_op     (req_fpu_op),
        .req_tag        (req_tag),
        .alu_opcode     (alu_opcode),
        .fpu_opcode     (fpu_opcode),
        .alu_fpu_select (alu_fpu_select),
        .dp_result      (dp_result),
        .dp_exception   (dp_exception),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_tag       (resp_tag),
        .resp_exception (resp_exception),
        .exc_clear      (exc_clear),
        .exc_sticky     (exc_sticky)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one transaction record plus its capture time.
    bit          m_known = 0;
    bit          m_busy;
    bit          m_resp;
    int          m_cyc = 0;
    int          m_cap;
    bit          m_op_fpu;
    logic [4:0]  m_op_tag;
    logic [2:0]  m_alu_op, m_fpu_op;
    logic        m_sel;
    logic [31:0] m_result;
    logic [4:0]  m_tag;
    logic        m_exc;
    logic        m_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, advance the model
    // to what the next rising edge must produce.
    task automatic step(input logic rst, input logic rv, input logic rfpu,
                        input logic [2:0] aop, input logic [2:0] fop, input logic [4:0] tg,
                        input logic [31:0] dres, input logic dexc, input logic fl,
                        input logic rr, input logic ec);
        bit cap_set;
        @(negedge CLK);
        reset = rst; req_valid = rv; req_fpu = rfpu; req_alu_op = aop; req_fpu_op = fop;
        req_tag = tg; dp_result = dres; dp_exception = dexc; flush = fl;
        resp_ready = rr; exc_clear = ec;
        #1;
        if (m_known) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy && !fl));
            check("resp_valid", 32'(resp_valid), 32'(m_resp));
            check("resp_result", resp_result, m_result);
            check("resp_tag", 32'(resp_tag), 32'(m_tag));
            check("resp_exception", 32'(resp_exception), 32'(m_exc));
            check("alu_opcode", 32'(alu_opcode), 32'(m_alu_op));
            check("fpu_opcode", 32'(fpu_opcode), 32'(m_fpu_op));
            check("alu_fpu_select", 32'(alu_fpu_select), 32'(m_sel));
            check("exc_sticky", 32'(exc_sticky), 32'(m_sticky));
        end
        cap_set = 0;
        if (rst) begin
            m_known = 1; m_busy = 0; m_resp = 0; m_alu_op = 0; m_fpu_op = 0; m_sel = 0;
            m_result = 0; m_tag = 0; m_exc = 0; m_sticky = 0;
        end else begin
            if (fl) begin
                m_busy = 0;
                m_resp = 0;
            end else if (!m_busy) begin
                if (rv) begin
                    m_busy = 1; m_op_fpu = rfpu; m_op_tag = tg;
                    m_alu_op = aop; m_fpu_op = fop; m_sel = rfpu;
                    m_cap = m_cyc + (rfpu ? int'(Lat) : 1);
                end
            end else if (!m_resp) begin
                if (m_cyc == m_cap) begin
                    m_resp = 1; m_result = dres; m_tag = m_op_tag;
                    m_exc = m_op_fpu ? dexc : 1'b0;
                    cap_set = m_op_fpu && dexc;
                end
            end else if (rr) begin
                m_busy = 0;
                m_resp = 0;
            end
`ifdef EXU_EXC_STICKY_EN
            if (cap_set) m_sticky = 1;
            else if (ec) m_sticky = 0;
`endif
        end
        m_cyc++;
    endtask

    task automatic idle(input logic [31:0] dres, input logic dexc, input logic rr);
        step(0, 0, 0, 3'd0, 3'd0, 5'd0, dres, dexc, 0, rr, 0);
    endtask

    initial begin
        // Reset, then ALU op with tag 5 and result 0xA.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 3'b000, 3'b111, 5'd5, 32'h0, 0, 0, 0, 0);
        idle(32'h0000_000A, 1, 0);
        idle(32'h1234_5678, 0, 1);
        idle(32'h0, 0, 0);

        // FPU op, latency 4, exception raised; then backpressure for 3 cycles.
        step(0, 1, 1, 3'b010, 3'b001, 5'd12, 32'h0, 0, 0, 0, 0);
        idle(32'hDEAD_0001, 1, 1);
        idle(32'hDEAD_0002, 1, 1);
        idle(32'hDEAD_0003, 1, 1);
        idle(32'h4040_0000, 1, 0);
        for (int i = 0; i < 3; i++) idle($urandom, 1'($urandom), 0);
        idle(32'h0, 0, 1);
        idle(32'h0, 0, 0);

        // Flush two cycles into FPU_WAIT, then flush racing a request in IDLE.
        step(0, 1, 1, 3'b100, 3'b011, 5'd7, 32'h0, 0, 0, 0, 0);
        idle(32'h1, 1, 1);
        idle(32'h2, 1, 1);
        step(0, 0, 0, 0, 0, 0, 32'h3, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) idle($urandom, 1, 1);
        step(0, 1, 0, 3'b101, 3'b110, 5'd30, 32'h0, 0, 1, 0, 0);
        idle(32'h0, 0, 0);

        // Reset during FPU_WAIT.
        step(0, 1, 1, 3'b001, 3'b010, 5'd9, 32'h0, 0, 0, 0, 0);
        idle(32'h55, 1, 0);
        step(1, 0, 0, 0, 0, 0, 32'h66, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle($urandom, 1, 1);

        // exc_clear coincident with an exception capture: set wins.
        step(0, 1, 1, 3'b011, 3'b101, 5'd21, 32'h0, 0, 0, 0, 1);
        idle(32'h0, 0, 0);
        idle(32'h0, 0, 0);
        idle(32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h3F80_0000, 1, 0, 0, 1);
        idle(32'h0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        idle(32'h0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom), 5'($urandom), $urandom, 1'($urandom),
                 1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exu_scheduler.md
EXU_SCHEDULER -- requirements
Module: exu_scheduler

Interface
REQ-001 Parameter: FPU_LATENCY, default 4, FPU cycles from operand issue to valid dp_result (legal 1..15).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  1  requester presents an operation.
REQ-005 Port: req_ready  output  1  scheduler can accept; request taken when req_valid && req_ready at a CLK edge.
REQ-006 Port: req_fpu  input  1  1 = route to FPU, 0 = route to ALU.
REQ-007 Port: req_alu_op  input  3  ALU opcode.
REQ-008 Port: req_fpu_op  input  3  FPU opcode.
REQ-009 Port: req_tag  input  5  destination register tag, returned with the result.
REQ-010 Port: alu_opcode  output  3  registered ALU opcode driven to the datapath.
REQ-011 Port: fpu_opcode  output  3  registered FPU opcode driven to the datapath.
REQ-012 Port: alu_fpu_select  output  1  registered datapath result select (1 = FPU).
REQ-013 Port: dp_result  input  32  datapath result.
REQ-014 Port: dp_exception  input  1  datapath exception (FPU only).
REQ-015 Port: flush  input  1  abort any in-flight operation.
REQ-016 Port: resp_valid  output  1  response available.
REQ-017 Port: resp_ready  input  1  consumer accepts; handshake on resp_valid && resp_ready.
REQ-018 Port: resp_result  output  32  captured result.
REQ-019 Port: resp_tag  output  5  tag of the completed operation.
REQ-020 Port: resp_exception  output  1  captured exception of the completed operation.
REQ-021 Port: exc_clear  input  1  clears exc_sticky.
REQ-022 Port: exc_sticky  output  1  accumulated exception flag.

Function
REQ-023 FSM states: IDLE, ALU_EXEC, FPU_WAIT, RESP; one operation in flight at most.
REQ-024 req_ready = (state == IDLE) && !flush; combinational.
REQ-025 On accept at edge N: latch req_alu_op, req_fpu_op, req_fpu, req_tag into alu_opcode, fpu_opcode, alu_fpu_select, tag register; next state ALU_EXEC if req_fpu=0, else FPU_WAIT with down-counter loaded with FPU_LATENCY-1.
REQ-026 Datapath control outputs hold their latched values until the next accept; unchanged in IDLE.
REQ-027 ALU_EXEC: at edge N+1 capture dp_result into resp_result, resp_exception <= 0, go RESP; resp_valid high from edge N+1.
REQ-028 FPU_WAIT: counter decrements each cycle; in the cycle counter == 0, capture dp_result and dp_exception at that edge (edge N+FPU_LATENCY) and go RESP.
REQ-029 RESP: resp_valid = 1; resp_result, resp_tag, resp_exception stable until handshake; on handshake go IDLE, req_ready high the following cycle.
REQ-030 resp_valid is 0 in every state except RESP.
REQ-031 flush in ALU_EXEC, FPU_WAIT or RESP: next state IDLE, no capture, no response, exc_sticky not updated; flush in RESP discards the pending response even if resp_ready is high.
REQ-032 flush in IDLE with req_valid high: no accept (flush wins).
REQ-033 Capture without flush during the capture cycle is the only event that updates resp_* outputs.

Reset
REQ-034 reset at any edge, including mid-operation: state IDLE, counter 0, alu_opcode 0, fpu_opcode 0, alu_fpu_select 0, resp_result 0, resp_tag 0, resp_exception 0, exc_sticky 0; reset dominates flush and req_valid.
REQ-035 req_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-036 Macro EXU_EXC_STICKY_EN defined: exc_sticky set at an FPU capture edge with dp_exception = 1, cleared by exc_clear; set wins over simultaneous clear.
REQ-037 Macro undefined: exc_sticky tied 0, exc_clear ignored, no sticky register synthesized; all other behaviour identical.

Verification
REQ-038 ALU: reset, accept req_fpu=0, req_alu_op=3'b000, req_tag=5, dp_result=0x0000000A -> resp_valid high one cycle after accept, resp_result=0x0000000A, resp_tag=5, resp_exception=0.
REQ-039 FPU, FPU_LATENCY=4: accept req_fpu=1, req_fpu_op=3'b001, req_tag=12, dp_result=0x40400000, dp_exception=1 -> resp_valid exactly 4 cycles after accept, resp_exception=1, exc_sticky=1 when macro defined, 0 otherwise.
REQ-040 Backpressure: hold resp_ready=0 for 3 cycles in RESP while dp_result changes -> resp_* stable, req_ready=0; handshake -> req_ready=1 next cycle.
REQ-041 flush asserted 2 cycles into FPU_WAIT -> IDLE next cycle, no resp_valid, exc_sticky unchanged; flush with req_valid in IDLE -> no accept.
REQ-042 reset asserted during FPU_WAIT, and exc_clear coincident with an exception capture -> all outputs at reset values; exc_sticky=1 after the coincident-event cycle.
